serial_add_sub: RTL and testbench

Bit-serial adder (optionally subtractor) that processes two WIDTH-bit operands LSB-first through a single full-adder cell, one bit per clock. It is the sequential datapath built on the team's combinational full-adder cell. A start/busy/done handshake gives an area-cheap arithmetic unit for control paths where WIDTH-cycle latency is acceptable.

---
 rtl/serial_alu_pkg.sv | 15 +
 rtl/fa_cell.sv | 13 +
 rtl/serial_add_sub.sv | 117 +++++++++++
 tb/tb_serial_add_sub.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared types and helpers for the bit-serial add/sub datapath.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder used as the serial arithmetic cell.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// LSB-first bit-serial adder with start/busy/done handshake.
// Define SERIAL_SUB_EN to add the sub port and two's-complement subtraction.
module serial_add_sub
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] work_next;
    logic             carry_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg;
    logic             overflow_reg;
    logic             done_reg;
    logic             sub_in;
    logic             s_bit;
    logic             c_bit;

`ifdef SERIAL_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    fa_cell u_fa (
        .a    (a_sr_reg[0]),
        .b    (b_sr_reg[0]),
        .cin  (carry_reg),
        .sum  (s_bit),
        .cout (c_bit)
    );

    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_work_w1
            assign work_next = s_bit;
        end else begin : g_work_wn
            assign work_next = {s_bit, work_reg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            a_sr_reg      <= '0;
            b_sr_reg      <= '0;
            work_reg      <= '0;
            carry_reg     <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= RUN;
                        a_sr_reg  <= op_a;
                        b_sr_reg  <= op_b ^ {WIDTH{sub_in}};
                        carry_reg <= sub_in;
                        count_reg <= '0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    a_sr_reg  <= a_sr_reg >> 1;
                    b_sr_reg  <= b_sr_reg >> 1;
                    work_reg  <= work_next;
                    carry_reg <= c_bit;
                    if (count_reg == LAST) begin
                        // carry_reg here is exactly the carry into the MSB cell.
                        state_reg     <= DONE;
                        result_reg    <= work_next;
                        carry_out_reg <= c_bit;
                        overflow_reg  <= carry_reg ^ c_bit;
                        done_reg      <= 1'b1;
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg == RUN);
    assign done      = done_reg;
    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8); honours SERIAL_SUB_EN.
module tb_serial_add_sub;

    localparam int W = 8;
`ifdef SERIAL_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
`ifdef SERIAL_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         output logic [W-1:0] r, output logic c, output logic v);
        int ua, ub, sa, sb, full, sres;
        ua = int'(a);
        ub = int'(b);
        sa = a[W-1] ? ua - (1 << W) : ua;
        sb = b[W-1] ? ub - (1 << W) : ub;
        if (s && HAS_SUB) begin
            full = ua - ub;
            c    = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub;
            c    = (full >= (1 << W));
            sres = sa + sb;
        end
        r = W'(full);
        v = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
    endtask

    // One operation; mode 1 disturbs start and operands mid-RUN.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         input int mode, input string tag);
        logic [W-1:0] er;
        logic         ec, ev;
        logic [W-1:0] held;
        int           lat;
        model(a, b, s, er, ec, ev);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        held  = result;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        lat = 0;
        for (int i = 1; i <= W + 3; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            checks++;
            assert (result === held)
            else begin
                errors++;
                $error("FAIL %s_stable: observed %0h expected %0h", tag, result, held);
            end
            if (mode == 1 && i == 2) begin
                start = 1'b1;
                op_a  = ~a;
                op_b  = b + 8'd1;
                sub   = ~s;
            end
            if (mode == 1 && i == 3) start = 1'b0;
        end
        chk({tag, "_latency"}, lat, W);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_result"}, result, er);
        chk({tag, "_carry"}, carry_out, ec);
        chk({tag, "_ovf"}, overflow, ev);
        @(negedge clk);
        chk({tag, "_done_single"}, done, 1'b0);
        $display("op %s a=%02h b=%02h sub=%0d -> result=%02h c=%0d v=%0d lat=%0d",
                 tag, a, b, s, result, carry_out, overflow, lat);
    endtask

    initial begin
        logic [W-1:0] er, er2;
        logic         ec, ev, ec2, ev2;
        int           first_done, second_done;

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        sub   = 1'b0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_carry", carry_out, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h0F, 8'h01, 1'b0, 0, "add_0f_01");
        do_op(8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
        do_op(8'h7F, 8'h01, 1'b0, 0, "add_7f_01");
        if (HAS_SUB) begin
            do_op(8'h05, 8'h07, 1'b1, 0, "sub_05_07");
            do_op(8'h80, 8'h01, 1'b1, 0, "sub_80_01");
        end
        do_op(8'h3C, 8'h5A, 1'b0, 1, "midrun");

        // Back-to-back with start held high across both operations.
        model(8'h12, 8'h34, 1'b0, er, ec, ev);
        model(8'hC8, 8'h9B, HAS_SUB, er2, ec2, ev2);
        @(negedge clk);
        op_a  = 8'h12;
        op_b  = 8'h34;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        first_done  = 0;
        second_done = 0;
        for (int i = 1; i <= 2 * W + 4; i++) begin
            @(negedge clk);
            if (i == W + 1) start = 1'b0;
            if (done && first_done == 0) begin
                first_done = i;
                chk("b2b_result1", result, er);
                chk("b2b_carry1", carry_out, ec);
                op_a = 8'hC8;
                op_b = 8'h9B;
                sub  = HAS_SUB;
            end else if (done && second_done == 0) begin
                second_done = i;
                chk("b2b_result2", result, er2);
                chk("b2b_carry2", carry_out, ec2);
                chk("b2b_ovf2", overflow, ev2);
            end
        end
        chk("b2b_first_done", first_done, W);
        chk("b2b_second_done", second_done, 2 * W + 1);
        $display("op b2b first_done=%0d second_done=%0d result=%02h", first_done, second_done, result);

        // Reset while RUN holds count 3.
        @(negedge clk);
        op_a  = 8'h21;
        op_b  = 8'h43;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_result", result, 8'h00);
        chk("arst_carry", carry_out, 1'b0);
        chk("arst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        first_done = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done) first_done = 1;
        end
        chk("arst_no_done", first_done, 0);
        $display("op reset_mid_run busy=%0d result=%02h", busy, result);
        do_op(8'h21, 8'h43, 1'b0, 0, "post_reset");

        for (int n = 0; n < 20; n++) begin
            logic [W-1:0] ra, rb;
            bit           rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = HAS_SUB ? bit'($urandom_range(0, 1)) : 1'b0;
            do_op(ra, rb, rs, 0, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
